// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor:
// opcode values, 2-bit counter encoding, BTB entry layout and PC field helpers.
package bp_pkg;

  // RV32 control-transfer opcodes (instr[6:0])
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;  // strongly not-taken
  localparam ctr2_t WNT = 2'b01;  // weakly not-taken
  localparam ctr2_t WT  = 2'b10;  // weakly taken
  localparam ctr2_t ST  = 2'b11;  // strongly taken

  // Tags are held zero-extended to the widest possible tag so the entry
  // layout does not depend on the table size.
  localparam int BP_TAG_MAX_W = 30;
  typedef logic [BP_TAG_MAX_W-1:0] bp_tag_t;

  typedef struct packed {
    logic        valid;
    bp_tag_t     tag;
    logic [31:0] target;
  } btb_entry_t;

  // Table index: pc[index_w+1:2], returned right-aligned.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int index_w);
    return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
  endfunction

  // Tag: the top tag_w bits of the PC, zero-extended.
  function automatic bp_tag_t pc_tag(input logic [31:0] pc, input int tag_w);
    return BP_TAG_MAX_W'(pc >> (32 - tag_w));
  endfunction

  function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state of a 2-bit saturating counter; 00 and 11 are sticky.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr2_t cur,
  input  logic  taken,
  output ctr2_t next
);

  // Count towards the resolved direction, holding at the ends.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'd1;
    end else begin
      if (cur != SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters plus a BTB.
// IF: combinational lookup of the registered tables for i_fetch_pc.
// EX: trains the tables from the resolved outcome and raises o_mispredict.
// Optional: define BP_STATS_EN to add o_br_cnt / o_miss_cnt event counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_instr,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int TAG_W   = 32 - INDEX_W - 2;
  localparam int ENTRIES = 1 << INDEX_W;

  // Storage: valid bits and counters need a reset value, tag/target do not.
  logic [ENTRIES-1:0] valid_q;
  ctr2_t              ctr_q [ENTRIES];
  bp_tag_t            tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  // ---------------- Lookup ----------------
  logic [INDEX_W-1:0] fetch_idx;
  bp_tag_t            fetch_tag;
  btb_entry_t         fetch_entry;
  logic               fetch_hit;

  assign fetch_idx   = INDEX_W'(pc_index(i_fetch_pc, INDEX_W));
  assign fetch_tag   = pc_tag(i_fetch_pc, TAG_W);
  assign fetch_entry = '{valid: valid_q[fetch_idx], tag: tag_q[fetch_idx], target: tgt_q[fetch_idx]};
  assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);

  // Predict taken only on a tag hit with a taken-leaning counter.
  always_comb begin
    o_pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    o_pred_target = o_pred_taken ? fetch_entry.target : i_fetch_pc + 32'd4;
  end

  // ---------------- Update ----------------
  logic [INDEX_W-1:0] upd_idx;
  bp_tag_t            upd_tag;
  logic [6:0]         upd_op;
  logic               upd_hit;
  logic               upd_is_ctl;
  ctr2_t              ctr_trained;

  assign upd_idx    = INDEX_W'(pc_index(i_upd_pc, INDEX_W));
  assign upd_tag    = pc_tag(i_upd_pc, TAG_W);
  assign upd_op     = instr_opcode(i_upd_instr);
  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_is_ctl = (upd_op == OP_BRANCH) || (upd_op == OP_JAL) || (upd_op == OP_JALR);

  bp_sat_ctr u_sat_ctr (
    .cur   (ctr_q[upd_idx]),
    .taken (i_upd_taken),
    .next  (ctr_trained)
  );

  logic       entry_we;
  btb_entry_t entry_wd;
  logic       ctr_we;
  ctr2_t      ctr_wd;

  // Decide which table fields the EX instruction writes this cycle.
  always_comb begin
    entry_we = 1'b0;
    entry_wd = '{valid: 1'b1, tag: upd_tag, target: i_upd_target};
    ctr_we   = 1'b0;
    ctr_wd   = WNT;
    if (i_upd_valid) begin
      case (upd_op)
        OP_JAL, OP_JALR: begin
          entry_we = 1'b1;
          ctr_we   = 1'b1;
          ctr_wd   = ST;
        end
        OP_BRANCH: begin
          if (upd_hit) begin
            // Tag already matches, so rewriting the entry only refreshes the target.
            entry_we = i_upd_taken;
            ctr_we   = 1'b1;
            ctr_wd   = ctr_trained;
          end else if (i_upd_taken) begin
            // Allocation replaces whatever aliased entry was there.
            entry_we = 1'b1;
            ctr_we   = 1'b1;
            ctr_wd   = WT;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid bits and counters: async reset clears every entry at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      // NOTE: this table is reset because a stale valid bit or counter would predict; tag/target below are not.
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WNT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
      if (entry_we) valid_q[upd_idx] <= entry_wd.valid;
      if (ctr_we)   ctr_q[upd_idx]   <= ctr_wd;
    end
  end

  // Tag/target payload: only meaningful behind a set valid bit, so no reset.
  always_ff @(posedge i_clk) begin
    if (entry_we) begin
      tag_q[upd_idx] <= entry_wd.tag;
      tgt_q[upd_idx] <= entry_wd.target;
    end
  end

  // Flush request: wrong direction, or taken with the wrong target.
  assign o_mispredict = i_upd_valid &&
                        ((i_upd_taken != i_upd_pred_taken) ||
                         (i_upd_taken && (i_upd_pred_target != i_upd_target)));

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (i_upd_valid && upd_is_ctl) br_cnt_q   <= br_cnt_q + 32'd1;
      if (o_mispredict)              miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt   = br_cnt_q;
  assign o_miss_cnt = miss_cnt_q;
`else
  // Classification is only needed by the statistics counters.
  logic unused_ctl;
  assign unused_ctl = upd_is_ctl;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with fixed
// expectations, then randomized traffic against a table-level reference model.
module tb_branch_predictor;

  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_fetch_pc = '0;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_pc = '0;
  logic [31:0] i_upd_instr = '0;
  logic        i_upd_taken = 1'b0;
  logic [31:0] i_upd_target = '0;
  logic        i_upd_pred_taken = 1'b0;
  logic [31:0] i_upd_pred_target = '0;
  logic        o_mispredict;
`ifdef BP_STATS_EN
  logic [31:0] o_br_cnt;
  logic [31:0] o_miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_fetch_pc        (i_fetch_pc),
    .o_pred_taken      (o_pred_taken),
    .o_pred_target     (o_pred_target),
    .i_upd_valid       (i_upd_valid),
    .i_upd_pc          (i_upd_pc),
    .i_upd_instr       (i_upd_instr),
    .i_upd_taken       (i_upd_taken),
    .i_upd_target      (i_upd_target),
    .i_upd_pred_taken  (i_upd_pred_taken),
`ifdef BP_STATS_EN
    .o_br_cnt          (o_br_cnt),
    .o_miss_cnt        (o_miss_cnt),
`endif
    .i_upd_pred_target (i_upd_pred_target),
    .o_mispredict      (o_mispredict)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- Reference model (one record per table slot) ----------------
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  int unsigned m_br, m_miss;

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_br = 0; m_miss = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int idx = int'((pc / 4) % 64);
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 256);
    t  = hit && (m_ctr[idx] >= 2);
    tg = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic logic model_misp(input logic v, input logic t, input logic pt,
                                      input logic [31:0] tg, input logic [31:0] ptg);
    if (!v) return 1'b0;
    if (t != pt) return 1'b1;
    return t && (tg != ptg);
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic [31:0] instr,
                                       input logic t, input logic [31:0] tg);
    int idx = int'((pc / 4) % 64);
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 256);
    logic [6:0] op = instr[6:0];
    if (op == 7'h6F || op == 7'h67) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 256; m_tgt[idx] = tg; m_ctr[idx] = 3;
    end else if (op == 7'h63) begin
      if (hit) begin
        m_ctr[idx] = t ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                       : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
        if (t) m_tgt[idx] = tg;
      end else if (t) begin
        m_valid[idx] = 1; m_tag[idx] = pc / 256; m_tgt[idx] = tg; m_ctr[idx] = 2;
      end
    end
  endfunction

  // ---------------- Stimulus helpers ----------------
  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic t, input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
    i_upd_valid = v; i_upd_pc = pc; i_upd_instr = instr; i_upd_taken = t;
    i_upd_target = tg; i_upd_pred_taken = pt; i_upd_pred_target = ptg;
  endtask

  task automatic idle_upd();
    drive_upd(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // ---------------- Scenarios ----------------
  task automatic test_reset();
    i_fetch_pc = 32'h0000_0100;
    #1;
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken_in_reset got=%0b want=0", o_pred_taken); end
    n_cmp++; if (o_pred_target !== 32'h104) begin n_err++; $display("FAIL reset_target_in_reset got=%h want=00000104", o_pred_target); end
    do_reset();
    #1;
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%0b want=0", o_pred_taken); end
    n_cmp++; if (o_pred_target !== 32'h104) begin n_err++; $display("FAIL reset_target got=%h want=00000104", o_pred_target); end
    i_fetch_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (o_pred_target !== 32'h0) begin n_err++; $display("FAIL reset_target_wrap got=%h want=00000000", o_pred_target); end
`ifdef BP_STATS_EN
    n_cmp++; if (o_br_cnt !== 32'd0 || o_miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stats got=%0d/%0d want=0/0", o_br_cnt, o_miss_cnt); end
`endif
    @(negedge i_clk);
  endtask

  task automatic test_branch_train();
    // Taken, predicted not-taken: mispredict, allocate with counter 10.
    i_fetch_pc = 32'h100;
    drive_upd(1'b1, 32'h100, I_BEQ, 1'b1, 32'h140, 1'b0, 32'h104);
    #1;
    n_cmp++; if (o_mispredict !== 1'b1) begin n_err++; $display("FAIL br_alloc_misp got=%0b want=1", o_mispredict); end
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL br_same_cycle_no_bypass got=%0b want=0", o_pred_taken); end
    @(negedge i_clk); idle_upd(); #1;
    n_cmp++; if (o_pred_taken !== 1'b1) begin n_err++; $display("FAIL br_alloc_taken got=%0b want=1", o_pred_taken); end
    n_cmp++; if (o_pred_target !== 32'h140) begin n_err++; $display("FAIL br_alloc_target got=%h want=00000140", o_pred_target); end
    // Two not-taken with taken predictions: 10 -> 01 -> 00, each a mispredict.
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      drive_upd(1'b1, 32'h100, I_BEQ, 1'b0, 32'h104, 1'b1, 32'h140);
      #1;
      n_cmp++; if (o_mispredict !== 1'b1) begin n_err++; $display("FAIL br_nt_misp[%0d] got=%0b want=1", k, o_mispredict); end
    end
    @(negedge i_clk); idle_upd(); #1;
    n_cmp++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin n_err++; $display("FAIL br_trained_nt got=%0b/%h want=0/00000104", o_pred_taken, o_pred_target); end
    // Third not-taken, correctly predicted: no flush, counter stays 00.
    drive_upd(1'b1, 32'h100, I_BEQ, 1'b0, 32'h104, 1'b0, 32'h104);
    #1;
    n_cmp++; if (o_mispredict !== 1'b0) begin n_err++; $display("FAIL br_correct_nt_misp got=%0b want=0", o_mispredict); end
    // One taken from 00 reaches only 01, so lookup must stay not-taken.
    @(negedge i_clk);
    drive_upd(1'b1, 32'h100, I_BEQ, 1'b1, 32'h140, 1'b0, 32'h104);
    @(negedge i_clk); idle_upd(); #1;
    n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL br_floor_sticky got=%0b want=0", o_pred_taken); end
    @(negedge i_clk);
  endtask

  task automatic test_jump();
    drive_upd(1'b1, 32'h200, I_JALR, 1'b1, 32'h300, 1'b0, 32'h204);
    @(negedge i_clk); idle_upd(); i_fetch_pc = 32'h200; #1;
    n_cmp++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h300) begin n_err++; $display("FAIL jalr_alloc got=%0b/%h want=1/00000300", o_pred_taken, o_pred_target); end
    drive_upd(1'b1, 32'h200, I_JALR, 1'b1, 32'h380, 1'b1, 32'h300);
    #1;
    n_cmp++; if (o_mispredict !== 1'b1) begin n_err++; $display("FAIL jalr_target_misp got=%0b want=1", o_mispredict); end
    @(negedge i_clk); idle_upd(); #1;
    n_cmp++; if (o_pred_target !== 32'h380) begin n_err++; $display("FAIL jalr_retarget got=%h want=00000380", o_pred_target); end
    // Non-control opcode never allocates.
    drive_upd(1'b1, 32'h304, I_ADDI, 1'b1, 32'h900, 1'b1, 32'h900);
    @(negedge i_clk); idle_upd(); i_fetch_pc = 32'h304; #1;
    n_cmp++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h308) begin n_err++; $display("FAIL other_no_alloc got=%0b/%h want=0/00000308", o_pred_taken, o_pred_target); end
    // Invalid update never flushes even with mismatched fields.
    drive_upd(1'b0, 32'h200, I_JAL, 1'b1, 32'h400, 1'b0, 32'h0);
    #1;
    n_cmp++; if (o_mispredict !== 1'b0) begin n_err++; $display("FAIL invalid_no_misp got=%0b want=0", o_mispredict); end
    @(negedge i_clk); idle_upd();
  endtask

  task automatic test_alias();
    do_reset();
    drive_upd(1'b1, 32'h100, I_BEQ, 1'b1, 32'h140, 1'b0, 32'h104);
    @(negedge i_clk);
    // Aliasing update and lookup at index 0 in the same cycle: old entry wins.
    drive_upd(1'b1, 32'h200, I_BEQ, 1'b1, 32'h280, 1'b0, 32'h204);
    i_fetch_pc = 32'h100; #1;
    n_cmp++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h140) begin n_err++; $display("FAIL alias_same_cycle got=%0b/%h want=1/00000140", o_pred_taken, o_pred_target); end
    @(negedge i_clk); idle_upd(); #1;
    n_cmp++; if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) begin n_err++; $display("FAIL alias_evicted got=%0b/%h want=0/00000104", o_pred_taken, o_pred_target); end
    i_fetch_pc = 32'h200; #1;
    n_cmp++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h280) begin n_err++; $display("FAIL alias_new got=%0b/%h want=1/00000280", o_pred_taken, o_pred_target); end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] pcs [3];
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
    drive_upd(1'b1, pcs[0], I_BEQ,  1'b1, 32'h500, 1'b0, 32'h0);
    @(negedge i_clk);
    drive_upd(1'b1, pcs[1], I_JAL,  1'b1, 32'h600, 1'b0, 32'h0);
    @(negedge i_clk);
    drive_upd(1'b1, pcs[2], I_JALR, 1'b1, 32'h700, 1'b0, 32'h0);
    @(negedge i_clk); idle_upd(); i_fetch_pc = pcs[1]; #1;
    n_cmp++; if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h600) begin n_err++; $display("FAIL mid_pre_reset got=%0b/%h want=1/00000600", o_pred_taken, o_pred_target); end
    #1 i_reset = 1'b1;  // between edges: must act without a clock
    for (int k = 0; k < 3; k++) begin
      i_fetch_pc = pcs[k]; #1;
      n_cmp++; if (o_pred_taken !== 1'b0 || o_pred_target !== pcs[k] + 32'd4) begin n_err++; $display("FAIL mid_in_reset[%0d] got=%0b/%h want=0/%h", k, o_pred_taken, o_pred_target, pcs[k] + 32'd4); end
    end
    drive_upd(1'b1, 32'h104, I_BEQ, 1'b1, 32'h500, 1'b0, 32'h0); #1;
    n_cmp++; if (o_mispredict !== 1'b1) begin n_err++; $display("FAIL misp_in_reset got=%0b want=1", o_mispredict); end
    idle_upd();
`ifdef BP_STATS_EN
    n_cmp++; if (o_br_cnt !== 32'd0 || o_miss_cnt !== 32'd0) begin n_err++; $display("FAIL mid_stats got=%0d/%0d want=0/0", o_br_cnt, o_miss_cnt); end
`endif
    @(negedge i_clk); i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_fetch_pc = pcs[k]; #1;
      n_cmp++; if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL mid_after_reset[%0d] got=%0b want=0", k, o_pred_taken); end
    end
    @(negedge i_clk);
  endtask

  task automatic test_random();
    logic        v, t, pt, et, em;
    logic [31:0] pc, instr, tg, ptg, etg;
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 9) != 0);
      pc = ($urandom_range(1, 4) << 8) | ($urandom_range(0, 3) << 2);
      case ($urandom_range(0, 5))
        0, 1, 2: instr = I_BEQ | ($urandom & 32'hFFFF_FF80);
        3:       instr = I_JAL;
        4:       instr = I_JALR;
        default: instr = I_ADDI;
      endcase
      t   = 1'($urandom_range(0, 1));
      tg  = {16'h0, 16'($urandom_range(0, 7) << 4)};
      pt  = 1'($urandom_range(0, 1));
      ptg = ($urandom_range(0, 2) != 0) ? tg : tg + 32'd4;
      drive_upd(v, pc, instr, t, tg, pt, ptg);
      i_fetch_pc = ($urandom_range(1, 4) << 8) | ($urandom_range(0, 3) << 2);
      #1;
      model_lookup(i_fetch_pc, et, etg);
      em = model_misp(v, t, pt, tg, ptg);
      n_cmp++; if (o_pred_taken !== et) begin n_err++; $display("FAIL rnd_taken[%0d] pc=%h got=%0b want=%0b", n, i_fetch_pc, o_pred_taken, et); end
      n_cmp++; if (o_pred_target !== etg) begin n_err++; $display("FAIL rnd_target[%0d] pc=%h got=%h want=%h", n, i_fetch_pc, o_pred_target, etg); end
      n_cmp++; if (o_mispredict !== em) begin n_err++; $display("FAIL rnd_misp[%0d] got=%0b want=%0b", n, o_mispredict, em); end
`ifdef BP_STATS_EN
      n_cmp++; if (o_br_cnt !== m_br || o_miss_cnt !== m_miss) begin n_err++; $display("FAIL rnd_stats[%0d] got=%0d/%0d want=%0d/%0d", n, o_br_cnt, o_miss_cnt, m_br, m_miss); end
`endif
      if (v && (instr[6:0] == 7'h63 || instr[6:0] == 7'h6F || instr[6:0] == 7'h67)) m_br++;
      if (em) m_miss++;
      if (v) model_update(pc, instr, t, tg);
      @(negedge i_clk);
    end
    idle_upd();
  endtask

  initial begin
    test_reset();
    test_branch_train();
    test_jump();
    test_alias();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor. It is the producer end of the branch-resolution path.
- In IF it predicts taken/not-taken and the target for the current PC.
- In EX it consumes the resolved outcome from the branch comparator (`pc_sel`) and trains its tables. It also flags mispredictions so the hazard unit can flush.
- Storage: a direct-mapped table of 2-bit saturating counters plus a BTB (tag, target, valid).

Parameters:
- INDEX_W, 6, log2 of table entries (64 entries). Index = pc[INDEX_W+1:2].
- TAG_W, 32-INDEX_W-2, tag width = pc[31:INDEX_W+2]. Derived; do not override.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_reset  in  1  asynchronous, active-high reset.
- i_fetch_pc  in  32  PC being fetched.
- o_pred_taken  out  1  1 = redirect fetch to o_pred_target.
- o_pred_target  out  32  predicted next PC.
- i_upd_valid  in  1  EX-stage instruction is valid (not bubble/flushed).
- i_upd_pc  in  32  PC of the EX instruction.
- i_upd_instr  in  32  EX instruction word, used for opcode decode.
- i_upd_taken  in  1  resolved outcome (comparator pc_sel).
- i_upd_target  in  32  resolved target address.
- i_upd_pred_taken  in  1  prediction made for this instruction, piped from IF.
- i_upd_pred_target  in  32  predicted target, piped from IF.
- o_mispredict  out  1  flush request, combinational, same cycle as update.

Behaviour:
- Reset (async, active-high, effective immediately):
  - all valid bits = 0;
  - all counters = 2'b01 (weakly not-taken);
  - hence o_pred_taken = 0 and o_pred_target = i_fetch_pc+4 while reset is asserted and after it.
  - Reset asserted mid-training discards every table entry; no partial state survives.
- Lookup (combinational, 0-cycle latency, reads registered tables):
  - hit = valid[idx] & (tag[idx] == i_fetch_pc tag field);
  - o_pred_taken = hit & ctr[idx][1];
  - o_pred_target = o_pred_taken ? btb_target[idx] : i_fetch_pc+4 (32-bit, wraps modulo 2^32).
- Update (registered at posedge i_clk when i_upd_valid = 1):
  - Classify by opcode: BRANCH 1100011, JAL 1101111, JALR 1100111. Any other opcode: no table write.
  - Branch, entry hit: counter saturates up if taken, down if not (00 and 11 are sticky). Target rewritten when taken.
  - Branch, miss, taken: allocate entry with valid=1, tag, target, counter = 2'b10.
  - Branch, miss, not taken: no allocation.
  - JAL/JALR: always allocate/overwrite, counter = 2'b11, target = i_upd_target.
- Mispredict:
  - o_mispredict = i_upd_valid & (i_upd_taken != i_upd_pred_taken | (i_upd_taken & i_upd_pred_target != i_upd_target)).
  - Held 0 when i_upd_valid = 0, independent of i_reset state.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents (no write-through bypass). The new value is visible from the next cycle.
- Aliasing: a tag mismatch overwrites the entry on allocation (replacement, not merge).

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - adds ports o_br_cnt[31:0] and o_miss_cnt[31:0];
  - o_br_cnt increments on every valid update whose opcode is branch/JAL/JALR;
  - o_miss_cnt increments when o_mispredict = 1;
  - both reset to 0 and wrap 0xFFFFFFFF -> 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package bp_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR;
  - typedef ctr2_t (logic [1:0]);
  - counter constants SNT/WNT/WT/ST;
  - struct btb_entry_t {valid, tag, target}.
- Sub-module bp_sat_ctr: combinational next-state of a 2-bit saturating counter (inputs cur, taken; output next). Instantiated once, on the update path.

Test Plan:
- Reset then fetch 0x0000_0100 -> o_pred_taken=0, o_pred_target=0x0000_0104.
- Update BEQ @0x100 taken, target 0x140, pred_taken=0 -> o_mispredict=1. Next cycle fetch 0x100 -> pred_taken=1, target 0x140 (counter 10).
- Same BEQ not-taken twice, pred_taken=1 -> o_mispredict=1 both times. Counter 10->01->00. Fetch 0x100 -> pred_taken=0. A third not-taken keeps counter 00.
- JALR @0x200, target 0x300, then again with target 0x380 and pred_target=0x300 -> o_mispredict=1 (target mismatch). Fetch 0x200 -> target 0x380.
- Alias: allocate taken branch @0x100, then taken branch @0x200 (same index for INDEX_W=6: 0x100 and 0x200 both give index 0) -> fetch 0x100 misses, pred_target=0x104. Same-cycle update+lookup at one index returns the old entry.
- Assert i_reset mid-sequence after three allocations -> every lookup returns not-taken/pc+4. With BP_STATS_EN, counters read 0.
